mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_pkg.sv | 23 ++
 rtl/mult_arbiter_if.sv | 32 +++
 rtl/mult_arbiter_mult.sv | 51 +++++
 rtl/mult_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the round-robin multiplier arbiter: default sizes,
// FSM state encoding and a constant-function log2 helper.
package mult_arbiter_pkg;

  localparam int NB_DEFAULT   = 10;
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Number of bits needed to index 'value' distinct items (minimum 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the
// multiplier arbiter. The master side drives requests and accepts results.
interface mult_arbiter_if
  import mult_arbiter_pkg::*;
#(
  parameter int NB   = NB_DEFAULT,
  parameter int NREQ = NREQ_DEFAULT
) ();

  localparam int IDW = clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*NB-1:0] req_a;
  logic [NREQ*NB-1:0] req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [2*NB-1:0]    resp_data;
  logic [IDW-1:0]     resp_id;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, busy
  );

endinterface

// File: rtl/mult_arbiter_mult.sv
// Sequential signed shift-add multiplier. A start pulse loads the operands;
// one multiplier bit is consumed per clock for nb clocks, then the product
// holds until the next start. The top bit of b carries negative weight,
// so the result is the exact two's-complement product. No reset: a start
// always reloads every register.
module multiplier_nb
  import mult_arbiter_pkg::*;
#(
  parameter int nb = NB_DEFAULT
) (
  input  logic                   clk,
  input  logic                   start,
  input  logic signed [nb-1:0]   a,
  input  logic signed [nb-1:0]   b,
  output logic signed [2*nb-1:0] product,
  output logic                   ready
);

  localparam int CW = clog2(nb + 1);

  logic signed [2*nb-1:0] acc;
  logic signed [2*nb-1:0] a_sh;
  logic signed [2*nb-1:0] addend;
  logic [nb-1:0]          b_sh;
  logic [CW-1:0]          cnt;

  // Partial product for the multiplier bit currently at the bottom of b_sh.
  always_comb begin
    addend = b_sh[0] ? a_sh : '0;
  end

  // Load on start, otherwise accumulate one bit per cycle; the final bit is
  // the sign bit and is subtracted.
  always_ff @(posedge clk) begin
    if (start) begin
      acc  <= '0;
      a_sh <= {{nb{a[nb-1]}}, a};
      b_sh <= b;
      cnt  <= CW'(nb);
    end else if (cnt != '0) begin
      acc  <= (cnt == CW'(1)) ? (acc - addend) : (acc + addend);
      a_sh <= a_sh <<< 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt - CW'(1);
    end
  end

  assign product = acc;
  assign ready   = (cnt == '0);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of a shared sequential multiplier. One
// requester is granted in IDLE, its operands are loaded for a single cycle,
// the multiplier runs for NB cycles, and the product is held in RESP until
// the consumer takes it.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int NB   = NB_DEFAULT,
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_arbiter_if.slave bus
);

  localparam int IDW = clog2(NREQ);
  localparam int CW  = clog2(NB);

  state_t               state;
  state_t               state_nxt;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       winner;
  logic [IDW-1:0]       cap_id;
  logic [CW-1:0]        run_cnt;
  logic signed [NB-1:0] cap_a;
  logic signed [NB-1:0] cap_b;
  logic [NREQ-1:0]      grant;
  logic                 grant_en;
  logic                 start;
  logic                 mult_ready;
  logic [2*NB-1:0]      product;

  // First valid requester at or after start_idx, wrapping around.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  start_idx);
    logic [IDW-1:0] pick;
    int             idx;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(start_idx) + k) % NREQ;
      if (valid[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  // Round-robin winner among the currently valid requesters.
  always_comb begin
    winner = rr_pick(bus.req_valid, rr_ptr);
  end

  // Next-state logic, grant and multiplier start.
  always_comb begin
    state_nxt = state;
    grant     = '0;
    grant_en  = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (|bus.req_valid)) begin
          grant_en  = 1'b1;
          grant     = NREQ'(1) << winner;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        start     = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (run_cnt == CW'(NB - 1)) state_nxt = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture the granted operands and move the search start past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      cap_id <= '0;
      cap_a  <= '0;
      cap_b  <= '0;
    end else if (grant_en) begin
      rr_ptr <= (int'(winner) == NREQ - 1) ? '0 : (winner + IDW'(1));
      cap_id <= winner;
      cap_a  <= bus.req_a[int'(winner)*NB +: NB];
      cap_b  <= bus.req_b[int'(winner)*NB +: NB];
    end
  end

  // Own cycle counter for RUN so the multiplier's ready is never relied on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             run_cnt <= '0;
    else if (state == LOAD) run_cnt <= '0;
    else if (state == RUN)  run_cnt <= run_cnt + CW'(1);
  end

  multiplier_nb #(.nb(NB)) u_mult (
    .clk     (clk),
    .start   (start),
    .a       (cap_a),
    .b       (cap_b),
    .product (product),
    .ready   (mult_ready)
  );

  // The multiplier must have finished by the time a result is presented.
  a_mult_done: assert property (@(posedge clk) disable iff (!rst_n)
                                (state == RESP) |-> mult_ready);

  assign bus.req_ready  = grant;
  assign bus.resp_valid = (state == RESP);
  assign bus.busy       = (state != IDLE);
  assign bus.resp_id    = cap_id;
  assign bus.resp_data  = product;

endmodule
